phy_tx_lane_sched: RTL

- Four-lane transmit scheduler that sits upstream of the 4:1 PHY TX lane multiplexer.
- Buffers byte traffic from four lane sources in small per-lane FIFOs.
- Decides each clk_4f cycle which lane owns the single serial 9-bit output slot, bit 8 = valid.
- Supports work-conserving round-robin or fixed TDM slotting (lane 0,1,2,3 rotation); idle slots emit a configurable idle symbol with valid low.

---
 rtl/phy_tx_lane_sched.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/phy_tx_lane_sched.sv
`default_nettype none
// ============================================================================
// Module   : phy_tx_lane_sched
// Brief    : Four-lane TX scheduler, per-lane byte FIFOs into one 9-bit slot.
// Revision : 1.0 - initial release
// ============================================================================
module phy_tx_lane_sched #(
  parameter int         DEPTH    = 4,
  parameter logic [7:0] IDLE_SYM = 8'hBC
) (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic [3:0]  in_valid,
  input  logic [31:0] in_data,
  output logic [3:0]  in_ready,
  input  logic [3:0]  lane_en,
  input  logic        tdm_mode,
  input  logic        flush,
  output logic [8:0]  data_out,
  output logic [1:0]  lane_out,
  output logic [3:0]  fifo_full
);

  localparam int                 c_PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                 c_CNT_W    = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

  logic [3:0]      w_push;
  logic [3:0]      w_pop;
  logic [3:0]      w_empty;
  logic [3:0]      w_full;
  logic [3:0]      w_elig;
  logic [3:0][7:0] w_head;
  logic            w_gnt_vld;
  logic [1:0]      w_gnt_lane;
  logic [1:0]      w_idx;
  logic [1:0]      rr_q, rr_d;
  logic [8:0]      data_out_q, data_out_d;
  logic [1:0]      lane_out_q, lane_out_d;

  assign in_ready = lane_en & ~w_full & {4{~flush & ~reset}};
  assign w_push   = in_valid & in_ready;
  assign w_elig   = lane_en & ~w_empty;
  assign w_pop    = w_gnt_vld ? (4'b0001 << w_gnt_lane) : 4'b0000;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0]         mem_q [DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q;
    logic [c_PTR_W-1:0] rd_ptr_q;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               full_q;

    always_comb begin
      cnt_d = cnt_q;
      case ({w_push[gi], w_pop[gi]})
        2'b10:   cnt_d = cnt_q + c_CNT_W'(1);
        2'b01:   cnt_d = cnt_q - c_CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    always_ff @(posedge clk_4f or posedge reset) begin
      if (reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        full_q   <= 1'b0;
      end else if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        full_q   <= 1'b0;
      end else begin
        if (w_push[gi]) wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
        if (w_pop[gi])  rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
        cnt_q  <= cnt_d;
        full_q <= (cnt_d == c_FULL_CNT);
      end
    end

    // Storage needs no reset; occupancy is tracked solely by cnt_q.
    always_ff @(posedge clk_4f) begin
      if (w_push[gi]) mem_q[wr_ptr_q] <= in_data[8*gi +: 8];
    end

    assign w_empty[gi] = (cnt_q == '0);
    assign w_full[gi]  = full_q;
    assign w_head[gi]  = mem_q[rd_ptr_q];
  end

  always_comb begin
    w_gnt_vld  = 1'b0;
    w_gnt_lane = 2'd0;
    w_idx      = 2'd0;
    if (!flush) begin
      if (tdm_mode) begin
        w_gnt_vld  = w_elig[rr_q];
        w_gnt_lane = rr_q;
      end else begin
        // Scan farthest offset first so the lane nearest rr_q wins last.
        for (int k = 3; k >= 0; k--) begin
          w_idx = rr_q + 2'(k);
          if (w_elig[w_idx]) begin
            w_gnt_vld  = 1'b1;
            w_gnt_lane = w_idx;
          end
        end
      end
    end
  end

  always_comb begin
    rr_d       = rr_q;
    data_out_d = {1'b0, IDLE_SYM};
    lane_out_d = 2'd0;
    if (flush) begin
      rr_d = 2'd0;
    end else if (tdm_mode) begin
      rr_d = rr_q + 2'd1;
    end else if (w_gnt_vld) begin
      rr_d = w_gnt_lane + 2'd1;
    end
    if (w_gnt_vld) begin
      data_out_d = {1'b1, w_head[w_gnt_lane]};
      lane_out_d = w_gnt_lane;
    end
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      rr_q       <= 2'd0;
      data_out_q <= {1'b0, IDLE_SYM};
      lane_out_q <= 2'd0;
    end else begin
      rr_q       <= rr_d;
      data_out_q <= data_out_d;
      lane_out_q <= lane_out_d;
    end
  end

  assign data_out  = data_out_q;
  assign lane_out  = lane_out_q;
  assign fifo_full = w_full;

endmodule
`default_nettype wire
